// File: rtl/result_display_reader.sv
// result_display_reader
//   Consumer end of the result-display handshake. Each element that the
//   producer presents with NEW_OUTPUT is captured and shown on Show_DATA.
//   Show_DATA stays high for at least HOLD_CYCLES cycles, and for as long as
//   NEW_OUTPUT stays high. When the frame is full, the next NEW_OUTPUT
//   request is answered with a one-cycle Done_Flag instead of a capture.
//   Optional feature macro: RESULT_CHECKSUM_EN. It adds a Checksum output
//   that holds the sum of the elements captured in the last completed frame.
module result_display_reader #(
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4,
  parameter int NUM_RESULTS = 9,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              En,
  input  logic              NEW_OUTPUT,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Show_DATA,
  output logic              Done_Flag,
  output logic [DATA_W-1:0] Disp_Data,
  output logic [IDX_W-1:0]  Disp_Index,
  output logic              Disp_Valid,
  output logic [7:0]        Frame_Count
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [DATA_W+3:0] Checksum
`endif
);

  // hold_cnt only has to hold HOLD_CYCLES-1; keep it at least one bit wide
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(NUM_RESULTS);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [HC_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic              show_reg, show_next;
  logic              done_reg, done_next;
  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic [7:0]        frame_reg, frame_next;
`ifdef RESULT_CHECKSUM_EN
  logic [DATA_W+3:0] acc_reg, acc_next;
  logic [DATA_W+3:0] cksum_reg, cksum_next;
`endif

  // State and output registers; reset drops Show_DATA at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= WAIT;
      idx_reg      <= '0;
      hold_cnt_reg <= '0;
      show_reg     <= 1'b0;
      done_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      index_reg    <= '0;
      frame_reg    <= '0;
`ifdef RESULT_CHECKSUM_EN
      acc_reg      <= '0;
      cksum_reg    <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      hold_cnt_reg <= hold_cnt_next;
      show_reg     <= show_next;
      done_reg     <= done_next;
      valid_reg    <= valid_next;
      data_reg     <= data_next;
      index_reg    <= index_next;
      frame_reg    <= frame_next;
`ifdef RESULT_CHECKSUM_EN
      acc_reg      <= acc_next;
      cksum_reg    <= cksum_next;
`endif
    end
  end

  // Next-state and next-output logic; the pulses default low every cycle
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    hold_cnt_next = hold_cnt_reg;
    show_next     = show_reg;
    done_next     = 1'b0;
    valid_next    = 1'b0;
    data_next     = data_reg;
    index_next    = index_reg;
    frame_next    = frame_reg;
`ifdef RESULT_CHECKSUM_EN
    acc_next      = acc_reg;
    cksum_next    = cksum_reg;
`endif
    case (state_reg)
      WAIT: begin
        show_next = 1'b0;
        if (En && NEW_OUTPUT) begin
          if (idx_reg < IDX_FULL) begin
            // Capture the element and start its display window
            data_next     = Data_In;
            index_next    = idx_reg;
            valid_next    = 1'b1;
            show_next     = 1'b1;
            hold_cnt_next = HOLD_LOAD;
            state_next    = HOLD;
`ifdef RESULT_CHECKSUM_EN
            acc_next      = acc_reg + {4'b0000, Data_In};
`endif
          end else begin
            // Frame full: this request is answered with Done_Flag, and
            // nothing is captured
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end
      HOLD: begin
        show_next = 1'b1;
        if ((hold_cnt_reg == '0) && !NEW_OUTPUT) begin
          // Minimum dwell has elapsed and the producer has acknowledged
          show_next  = 1'b0;
          idx_next   = idx_reg + IDX_W'(1);
          state_next = WAIT;
        end else if (hold_cnt_reg != '0) begin
          hold_cnt_next = hold_cnt_reg - HC_W'(1);
        end
      end
      DONE: begin
        // Done_Flag drops after its single cycle; NEW_OUTPUT is ignored here
        show_next  = 1'b0;
        idx_next   = '0;
        frame_next = frame_reg + 8'd1;
        state_next = WAIT;
`ifdef RESULT_CHECKSUM_EN
        cksum_next = acc_reg;
        acc_next   = '0;
`endif
      end
      default: begin
        state_next = WAIT;
        show_next  = 1'b0;
      end
    endcase
  end

  assign Show_DATA   = show_reg;
  assign Done_Flag   = done_reg;
  assign Disp_Valid  = valid_reg;
  assign Disp_Data   = data_reg;
  assign Disp_Index  = index_reg;
  assign Frame_Count = frame_reg;
`ifdef RESULT_CHECKSUM_EN
  assign Checksum    = cksum_reg;
`endif

endmodule
